maze_loader: RTL and testbench
==============================

// Module: maze_loader
// PURPOSE
//  Builds the wall map for each new round and raises maze_ready to the round/game FSM.
//  - Triggered when game_end enters 2'b01 (new_round).
//  - Picks a layout index from a free-running LFSR.
//  - Copies that layout from the layout ROM into the wall RAM read by the renderer and collision logic.
//  - Forces solid outer borders on every cell it writes.
// PARAMETERS
//  MAZE_W       16     maze width in cells
//  MAZE_H       12     maze height in cells; CELLS = MAZE_W*MAZE_H (192)
//  NUM_LAYOUTS  4      stored layouts; power of two, >= 2
//  LFSR_SEED    8'hA5  LFSR reset value; must be nonzero
// PORTS
//  CLK          in   1    system clock
//  RESET        in   1    asynchronous, active-low reset
//  game_end     in   2    round status from the game FSM; 2'b01 = new_round
//  rom_addr     out  clog2(NUM_LAYOUTS*CELLS)  layout ROM address = layout_sel*CELLS + cell index
//  rom_data     in   2    ROM word, valid 1 cycle after rom_addr; bit0 = right wall, bit1 = bottom wall
//  ram_we       out  1    wall RAM write enable
//  ram_addr     out  clog2(CELLS)  wall RAM cell index, row-major
//  ram_wdata    out  2    wall bits written to the RAM
//  layout_sel   out  clog2(NUM_LAYOUTS)  layout chosen for the current round
//  maze_ready   out  1    maze fully written; stays high until game_end leaves 2'b01
// BEHAVIOUR
//  Reset (asynchronous, RESET=0):
//  - State = IDLE; lfsr = LFSR_SEED; prev_layout = 0.
//  - All outputs 0: maze_ready, ram_we, ram_addr, ram_wdata, rom_addr, layout_sel.
//  - Reset mid-fill stops writes immediately; the partially written RAM is not cleaned.
//  LFSR:
//  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; advances every cycle in every state; never 0.
//  Trigger: edge-qualified, game_end==2'b01 AND the registered previous game_end != 2'b01.
//  - A level that stays at 2'b01 never retriggers.
//  - 2'b01 asserted directly out of reset counts as an edge (previous value resets to 2'b00).
//  FSM states: IDLE -> PICK -> FILL -> DRAIN -> DONE -> IDLE.
//  - IDLE: outputs idle. Trigger seen at edge T0 -> PICK.
//  - PICK (1 cycle): cand = lfsr[clog2(NUM_LAYOUTS)-1:0].
//      If cand == prev_layout, cand = cand+1 mod NUM_LAYOUTS.
//      layout_sel <= cand; prev_layout <= cand; cell index i <= 0.
//  - FILL: rom_addr = layout_sel*CELLS + i; i increments once per cycle.
//      Leaves for DRAIN after issuing i = CELLS-1.
//  - DRAIN (1 cycle): completes the final write.
//  - Write timing: cell i is written in the cycle after its rom_addr was presented.
//      ram_we=1, ram_addr=i, ram_wdata=rom_data with the border forcing below.
//      ram_we is high exactly CELLS consecutive cycles, from T0+2 through T0+CELLS+1.
//  - Border forcing:
//      Column MAZE_W-1 forces bit0=1.
//      Row MAZE_H-1 forces bit1=1.
//      Column and row are tracked by wrap counters; no divider.
//  - DONE: maze_ready=1 from edge T0+CELLS+2 (194 cycles at defaults).
//      Held while game_end==2'b01.
//      When game_end!=2'b01 is sampled, maze_ready drops the next cycle and the state returns to IDLE.
//  Abort:
//  - game_end leaving 2'b01 during PICK, FILL or DRAIN -> IDLE next edge.
//  - ram_we=0 from that edge on; maze_ready stays 0; prev_layout keeps its new value.
//  Counters: i, row and column use exact widths; i never exceeds CELLS-1; no wrap in ROM address arithmetic.
// TESTING
//  1 Reset:
//    - Assert RESET=0 mid-FILL -> same-cycle async clear: ram_we=0, maze_ready=0, layout_sel=0.
//    - Release, pulse game_end 00->01 -> a fresh full fill.
//  2 Nominal:
//    - game_end 00->01 at T0, ROM returns all 0 -> ram_we high T0+2..T0+193, 192 writes in address order 0..191.
//    - maze_ready rises at T0+194.
//  3 Border:
//    - All-zero ROM -> cell 15 = 2'b01, cell 176 = 2'b10, cell 191 = 2'b11, cell 0 = 2'b00.
//  4 No repeat:
//    - Force lfsr low bits equal to prev_layout=2 at PICK -> layout_sel=3; rom_addr starts at 576.
//    - With prev_layout=3 and cand=3, wrap -> layout_sel=0.
//  5 Handshake:
//    - Hold game_end=01 for 300 cycles after ready -> maze_ready stays 1, no retrigger.
//    - game_end->00 -> maze_ready=0 one cycle later, FSM in IDLE.
//  6 Abort:
//    - game_end 01->00 at cell 50 -> no further ram_we, maze_ready never asserts.
//    - Next 00->01 gives a complete 192-write fill.

Source files
------------

// File: rtl/maze_loader.sv
// Round maze builder: on a new_round edge picks a layout from an LFSR, streams it
// from the layout ROM into the wall RAM with forced outer borders, then raises maze_ready.
module maze_loader #(
    parameter int          MAZE_W      = 16,
    parameter int          MAZE_H      = 12,
    parameter int          NUM_LAYOUTS = 4,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    localparam int         CELLS       = MAZE_W * MAZE_H,
    localparam int         ROM_AW      = $clog2(NUM_LAYOUTS * CELLS),
    localparam int         RAM_AW      = $clog2(CELLS),
    localparam int         SEL_W       = $clog2(NUM_LAYOUTS),
    localparam int         COL_W       = $clog2(MAZE_W),
    localparam int         ROW_W       = $clog2(MAZE_H)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        game_end,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [1:0]        rom_data,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [1:0]        ram_wdata,
    output logic [SEL_W-1:0]  layout_sel,
    output logic              maze_ready,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        FILL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [1:0]        prev_ge_q, prev_ge_d;
    logic [SEL_W-1:0]  prev_layout_q, prev_layout_d;
    logic [SEL_W-1:0]  layout_sel_q, layout_sel_d;
    logic [RAM_AW-1:0] i_q, i_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              wr_valid_q, wr_valid_d;
    logic [RAM_AW-1:0] wr_addr_q, wr_addr_d;
    logic              wr_col_last_q, wr_col_last_d;
    logic              wr_row_last_q, wr_row_last_d;

    logic              in_round;
    logic              trigger;
    logic [SEL_W-1:0]  cand;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            prev_ge_q     <= 2'b00;
            prev_layout_q <= '0;
            layout_sel_q  <= '0;
            i_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_col_last_q <= 1'b0;
            wr_row_last_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            prev_ge_q     <= prev_ge_d;
            prev_layout_q <= prev_layout_d;
            layout_sel_q  <= layout_sel_d;
            i_q           <= i_d;
            col_q         <= col_d;
            row_q         <= row_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_col_last_q <= wr_col_last_d;
            wr_row_last_q <= wr_row_last_d;
        end
    end

    always_comb begin
        in_round      = (game_end == 2'b01);
        trigger       = in_round && (prev_ge_q != 2'b01);
        cand          = lfsr_q[SEL_W-1:0];
        if (cand == prev_layout_q) begin
            cand = cand + SEL_W'(1);
        end

        state_d       = state_q;
        lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        prev_ge_d     = game_end;
        prev_layout_d = prev_layout_q;
        layout_sel_d  = layout_sel_q;
        i_d           = i_q;
        col_d         = col_q;
        row_d         = row_q;
        // Write stage trails the ROM address by one cycle to line up with rom_data.
        wr_valid_d    = (state_q == FILL) && in_round;
        wr_addr_d     = i_q;
        wr_col_last_d = (col_q == COL_W'(MAZE_W - 1));
        wr_row_last_d = (row_q == ROW_W'(MAZE_H - 1));

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                layout_sel_d  = cand;
                prev_layout_d = cand;
                i_d           = '0;
                col_d         = '0;
                row_d         = '0;
                state_d       = in_round ? FILL : IDLE;
            end
            FILL: begin
                if (!in_round) begin
                    state_d = IDLE;
                end else if (i_q == RAM_AW'(CELLS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + RAM_AW'(1);
                    if (col_q == COL_W'(MAZE_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                state_d = in_round ? DONE : IDLE;
            end
            DONE: begin
                if (!in_round) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // maze_ready is a level: it rises once the last cell is written and is held
    // for as long as game_end stays at new_round; dropping game_end releases it.
    assign maze_ready = (state_q == DONE);
    assign rom_addr   = (state_q == FILL)
                      ? ROM_AW'(layout_sel_q) * ROM_AW'(CELLS) + ROM_AW'(i_q)
                      : '0;
    assign ram_we     = wr_valid_q;
    assign ram_addr   = wr_valid_q ? wr_addr_q : '0;
    assign ram_wdata  = wr_valid_q ? {rom_data[1] | wr_row_last_q, rom_data[0] | wr_col_last_q}
                                   : 2'b00;
    assign layout_sel = layout_sel_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_maze_loader.sv
// Directed bench for maze_loader: ROM model, LFSR reference model and a write scoreboard.
module tb_maze_loader;

  localparam int CELLS = 192;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] game_end = 2'b00;
  logic [9:0] rom_addr;
  logic [1:0] rom_data = 2'b00;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [1:0] ram_wdata;
  logic [1:0] layout_sel;
  logic       maze_ready;
  logic [2:0] state_dbg;

  maze_loader dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .game_end   (game_end),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .layout_sel (layout_sel),
    .maze_ready (maze_ready),
    .state_dbg  (state_dbg)
  );

  // clock / reset-relative cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  logic [1:0] wall [CELLS];
  logic       rom_zero = 1'b1;
  int         tb_prev = 0;
  int         exp_layout = 0;
  int         t0 = 0;
  int         we_count = 0;
  int         first_we = -1;
  int         last_we = -1;
  logic [7:0] m;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [1:0] rom_fn(input logic [9:0] a);
    return a[1:0] ^ a[3:2] ^ a[9:8];
  endfunction

  // reference LFSR, stepped on the same edges as the design
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) m <= 8'hA5;
    else        m <= lfsr_step(m);
  end

  always @(posedge CLK) rom_data <= rom_zero ? 2'b00 : rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // write monitor / scoreboard pop
  always @(negedge CLK) begin
    logic [9:0] e;
    if (RESET && ram_we) begin
      we_count++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      wall[ram_addr] = ram_wdata;
      chk("write_queued", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ram_write", {22'd0, ram_addr, ram_wdata}, {22'd0, e});
      end
    end
  end

  // driver: waits for an LFSR state giving the wanted candidate/final layout, then triggers
  task automatic start_round(input int want_cand, input int want_final, input int n_push);
    logic [7:0] nxt;
    logic [1:0] d;
    int cand, fin, found;
    found = 0;
    cand = 0;
    fin = 0;
    for (int g = 0; g < 600; g++) begin
      nxt = lfsr_step(m);
      cand = int'(nxt[1:0]);
      fin = (cand == tb_prev) ? (cand + 1) % 4 : cand;
      if ((want_cand < 0 || cand == want_cand) && (want_final < 0 || fin == want_final)) begin
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("lfsr_search", found, 1);
    exp_layout = fin;
    tb_prev = fin;
    for (int i = 0; i < n_push; i++) begin
      d = rom_zero ? 2'b00 : rom_fn(10'(fin * CELLS + i));
      if (i % 16 == 15) d[0] = 1'b1;
      if (i / 16 == 11) d[1] = 1'b1;
      exp_q.push_back({8'(i), d});
    end
    we_count = 0;
    first_we = -1;
    last_we = -1;
    game_end = 2'b01;
    t0 = cyc + 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rom_addr_start", {22'd0, rom_addr}, fin * CELLS);
    chk("layout_sel", {30'd0, layout_sel}, fin);
  endtask

  task automatic finish_round(input int hold);
    int found, rc, bad;
    found = 0;
    rc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (maze_ready) begin
        found = 1;
        rc = cyc;
        break;
      end
    end
    chk("ready_seen", found, 1);
    chk("ready_time", rc, t0 + 194);
    chk("we_count", we_count, CELLS);
    chk("first_we", first_we, t0 + 2);
    chk("last_we", last_we, t0 + 193);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("layout_hold", {30'd0, layout_sel}, exp_layout);
    bad = 0;
    repeat (hold) begin
      @(negedge CLK);
      if (!maze_ready || ram_we) bad++;
    end
    chk("hold_stable", bad, 0);
    game_end = 2'b00;
    @(negedge CLK);
    chk("ready_drop", {31'd0, maze_ready}, 0);
    chk("state_idle", {29'd0, state_dbg}, 0);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 1000; k++) begin
      if (cyc == target) break;
      @(negedge CLK);
    end
    chk("reach_cycle", cyc, target);
  endtask

  initial begin
    int bad;
    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_ram_we", {31'd0, ram_we}, 0);
    chk("rst_ready", {31'd0, maze_ready}, 0);
    chk("rst_layout", {30'd0, layout_sel}, 0);
    chk("rst_rom_addr", {22'd0, rom_addr}, 0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 0);
    chk("rst_ram_wdata", {30'd0, ram_wdata}, 0);
    chk("rst_state", {29'd0, state_dbg}, 0);
    RESET = 1'b1;
    @(negedge CLK);

    // nominal fill, all-zero ROM, border cells, long hold
    rom_zero = 1'b1;
    start_round(-1, -1, CELLS);
    finish_round(300);
    chk("cell0", {30'd0, wall[0]}, 2'b00);
    chk("cell15", {30'd0, wall[15]}, 2'b01);
    chk("cell176", {30'd0, wall[176]}, 2'b10);
    chk("cell191", {30'd0, wall[191]}, 2'b11);

    // no-repeat rule on a patterned ROM
    rom_zero = 1'b0;
    if (tb_prev != 2) begin
      start_round(-1, 2, CELLS);
      finish_round(3);
    end
    start_round(2, -1, CELLS);
    chk("repeat_bump", exp_layout, 3);
    finish_round(3);
    start_round(3, -1, CELLS);
    chk("repeat_wrap", exp_layout, 0);
    finish_round(3);

    // abort at cell 50, then a complete fill
    start_round(-1, -1, 50);
    wait_cyc(t0 + 51);
    game_end = 2'b00;
    bad = 0;
    repeat (300) begin
      @(negedge CLK);
      if (maze_ready || ram_we) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_we_count", we_count, 50);
    chk("abort_exp_q", exp_q.size(), 0);
    chk("abort_state", {29'd0, state_dbg}, 0);
    start_round(-1, -1, CELLS);
    finish_round(3);

    // asynchronous reset mid-fill, then a fresh fill
    start_round(-1, -1, CELLS);
    wait_cyc(t0 + 100);
    RESET = 1'b0;
    #1;
    chk("async_ram_we", {31'd0, ram_we}, 0);
    chk("async_ready", {31'd0, maze_ready}, 0);
    chk("async_layout", {30'd0, layout_sel}, 0);
    exp_q.delete();
    tb_prev = 0;
    game_end = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    start_round(-1, -1, CELLS);
    finish_round(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
